// File: rtl/regfile_pkg.sv
// regfile_pkg: shared clear-FSM state type, default geometry and address range check for regfile_param
package regfile_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DONE  = 2'd2
    } clr_state_t;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_DEPTH = 8;

    function automatic logic addr_ok(input int unsigned addr, input int unsigned depth);
        return addr < depth;
    endfunction

endpackage

// File: rtl/regfile_clr_seq.sv
// regfile_clr_seq: clear sequencer that zeroes one register per cycle, then pulses done for one cycle
module regfile_clr_seq
    import regfile_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clr_req,
    output logic          clr_busy,
    output logic          clr_done,
    output logic          clr_we,
    output logic [AW-1:0] clr_addr
);

    clr_state_t    state, state_n;
    logic [AW-1:0] ptr, ptr_n;

    // State and sweep pointer registers; reset aborts any sweep in progress
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            ptr   <= '0;
        end else begin
            state <= state_n;
            ptr   <= ptr_n;
        end
    end

    // Next state: the pointer only advances while sweeping and is parked at 0 otherwise
    always_comb begin
        state_n = state;
        ptr_n   = '0;
        unique case (state)
            IDLE:    if (clr_req) state_n = SWEEP;
            SWEEP: begin
                ptr_n = ptr + 1'b1;
                if (ptr == AW'(DEPTH - 1)) state_n = DONE;
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    assign clr_busy = state == SWEEP;
    assign clr_done = state == DONE;
    assign clr_we   = clr_busy;
    assign clr_addr = ptr;

endmodule

// File: rtl/regfile_param.sv
// regfile_param: WIDTHxDEPTH register file, one write port, two combinational read ports, hardware clear sweep.
// Define REGFILE_BYPASS_EN to forward accepted write data to matching read ports in the same cycle.
module regfile_param
    import regfile_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] d_in,
    input  logic [AW-1:0]    rd_addr_a,
    input  logic [AW-1:0]    rd_addr_b,
    output logic [WIDTH-1:0] d_out_a,
    output logic [WIDTH-1:0] d_out_b,
    input  logic             clr_req,
    output logic             clr_busy,
    output logic             clr_done,
    output logic             wr_drop
);

    logic [WIDTH-1:0] regs [DEPTH];
    logic             clr_we;
    logic [AW-1:0]    clr_addr;
    logic             wr_ok;
    logic [WIDTH-1:0] a_q, b_q;

    regfile_clr_seq #(.DEPTH(DEPTH)) u_clr (
        .clk      (clk),
        .reset    (reset),
        .clr_req  (clr_req),
        .clr_busy (clr_busy),
        .clr_done (clr_done),
        .clr_we   (clr_we),
        .clr_addr (clr_addr)
    );

    // The sweep owns the array while busy, so a user write is either accepted alone or dropped
    assign wr_ok   = wr && !clr_busy && addr_ok(32'(wr_addr), DEPTH);
    assign wr_drop = wr && !wr_ok;

    // Register array: async clear on reset, sweep zeroing, then accepted writes
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
        end else if (clr_we) begin
            regs[clr_addr] <= '0;
        end else if (wr_ok) begin
            regs[wr_addr] <= d_in;
        end
    end

    assign a_q = addr_ok(32'(rd_addr_a), DEPTH) ? regs[rd_addr_a] : '0;
    assign b_q = addr_ok(32'(rd_addr_b), DEPTH) ? regs[rd_addr_b] : '0;

`ifdef REGFILE_BYPASS_EN
    assign d_out_a = (wr_ok && wr_addr == rd_addr_a) ? d_in : a_q;
    assign d_out_b = (wr_ok && wr_addr == rd_addr_b) ? d_in : b_q;
`else
    assign d_out_a = a_q;
    assign d_out_b = b_q;
`endif

endmodule
